// File: rtl/sample_fifo.sv
// Sample FIFO between the mixer and the delta-sigma DAC.
// The mixer writes whenever space is available; the DAC side pops one sample per
// sample tick once the buffer has been prefilled. An empty buffer at a tick is an
// underrun: the sticky flag is set and the FIFO goes back to prefilling.
// Optional feature macro: SAMPLE_FIFO_UNDERRUN_HOLD_EN. When defined, ticks that
// cannot pop repeat the last DAC sample. When undefined, they output silence (0).
module sample_fifo #(
  parameter int unsigned DW      = 24,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned PREFILL = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_valid,
  input  logic [DW-1:0]            i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_sample_tick,
  output logic [DW-1:0]            o_dac_data,
  output logic                     o_dac_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_underrun,
  input  logic                     i_clr_underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] DepthLvl   = LW'(DEPTH);
  localparam logic [LW-1:0] PrefillLvl = LW'(PREFILL);
  localparam logic [AW-1:0] LastPtr    = AW'(DEPTH - 1);

  typedef enum logic {StFill, StRun} state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [DW-1:0]   dac_data_q;
  logic            dac_valid_q;
  logic            underrun_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            wr_ready;
  logic            wr_en;
  logic            tick_run;
  logic            pop;
  logic            underrun_evt;
  logic [DW-1:0]   fill_data;

  // Handshake and pop decode, all from registered state so ready has no input path
  always_comb begin
    wr_ready     = (level_q < DepthLvl);
    wr_en        = i_wr_valid && wr_ready;
    tick_run     = i_sample_tick && (state_q == StRun);
    // A write in the same cycle cannot rescue an empty buffer
    pop          = tick_run && (level_q != '0);
    underrun_evt = tick_run && (level_q == '0);
`ifdef SAMPLE_FIFO_UNDERRUN_HOLD_EN
    fill_data    = dac_data_q;
`else
    fill_data    = '0;
`endif
  end

  // Pointer and occupancy next-state; level is a counter, not a pointer difference
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + AW'(1);
    end
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; deliberately not reset, contents are invalidated by the pointers
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Playout FSM with registered DAC outputs and sticky underrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFill;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // Every tick produces a DAC update one clock later, in either state
      dac_valid_q <= i_sample_tick;
      unique case (state_q)
        StFill: begin
          if (i_sample_tick) begin
            dac_data_q <= fill_data;
          end
          if (level_q >= PrefillLvl) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (i_sample_tick) begin
            if (level_q != '0) begin
              dac_data_q <= mem_q[rd_ptr_q];
            end else begin
              dac_data_q <= fill_data;
              state_q    <= StFill;
            end
          end
        end
        default: state_q <= StFill;
      endcase
      // A new underrun takes priority over a coincident clear
      if (underrun_evt) begin
        underrun_q <= 1'b1;
      end else if (i_clr_underrun) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign o_wr_ready  = wr_ready;
  assign o_dac_data  = dac_data_q;
  assign o_dac_valid = dac_valid_q;
  assign o_level     = level_q;
  assign o_underrun  = underrun_q;

  // Occupancy must stay within 0..DEPTH
  a_level_bound: assert property (@(posedge clk) disable iff (reset) level_q <= DepthLvl);

  // A write is never accepted while full
  a_no_write_full: assert property (@(posedge clk) disable iff (reset)
                                    (level_q == DepthLvl) |-> !wr_en);

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: ticks push the hand-computed expected DAC
// sample, a negedge monitor pops and compares on every o_dac_valid pulse.
module tb_sample_fifo;

  localparam int DW      = 24;
  localparam int DEPTH   = 128;
  localparam int PREFILL = 64;
  localparam int LW      = $clog2(DEPTH) + 1;

`ifdef SAMPLE_FIFO_UNDERRUN_HOLD_EN
  localparam int HoldVal = 135;
`else
  localparam int HoldVal = 0;
`endif

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          sample_tick;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic [LW-1:0] level;
  logic          underrun;
  logic          clr_underrun;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  logic [DW-1:0] sb[$];

  sample_fifo #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_wr_valid     (wr_valid),
    .i_wr_data      (wr_data),
    .o_wr_ready     (wr_ready),
    .i_sample_tick  (sample_tick),
    .o_dac_data     (dac_data),
    .o_dac_valid    (dac_valid),
    .o_level        (level),
    .o_underrun     (underrun),
    .i_clr_underrun (clr_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: every DAC update must match the oldest expected sample
  always @(negedge clk) begin
    if (dac_valid) begin
      vcount++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL dac_unexpected: actual=%0d required=no pulse", dac_data);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (dac_data !== exp) begin
          errors++;
          $display("FAIL dac_data: actual=%0d required=%0d", dac_data, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_n(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(start + i);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic tick(input int exp);
    sb.push_back(DW'(exp));
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    wr_valid     = 1'b0;
    wr_data      = '0;
    sample_tick  = 1'b0;
    clr_underrun = 1'b0;
    #1;
    chk("reset_level", level, 0);
    chk("reset_ready", wr_ready, 1);
    chk("reset_dac_data", dac_data, 0);
    chk("reset_dac_valid", dac_valid, 0);
    chk("reset_underrun", underrun, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Prefill: a tick while filling gives the fill output and does not pop
    write_n(1, 10);
    chk("fill_level10", level, 10);
    tick(0);
    idle(1);
    chk("fill_tick_no_pop", level, 10);
    write_n(11, 54);
    idle(3);
    chk("prefill_level64", level, 64);
    chk("prefill_no_extra_valid", vcount, 1);

    // Playout, one tick every 4 clocks
    for (int k = 1; k <= 5; k++) begin
      tick(k);
      chk("run_level_dec", level, 64 - k);
      idle(3);
    end

    // Fill to capacity across the pointer wrap
    write_n(65, 69);
    chk("full_level", level, 128);
    chk("full_ready_low", wr_ready, 0);
    wr_valid = 1'b1;
    wr_data  = DW'(999);
    idle(1);
    wr_valid = 1'b0;
    chk("full_write_ignored", level, 128);

    // Pop and write together while full: pop wins, write lands next cycle
    sb.push_back(DW'(6));
    sample_tick = 1'b1;
    wr_valid    = 1'b1;
    wr_data     = DW'(134);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    chk("full_pop_refuses_write", level, 127);
    chk("full_pop_ready_rises", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("full_write_next_cycle", level, 128);

    for (int v = 7; v <= 124; v++) begin
      tick(v);
      idle(1);
    end
    chk("drain_level10", level, 10);

    // Same-cycle tick and write keep the level
    sb.push_back(DW'(125));
    sample_tick = 1'b1;
    wr_valid    = 1'b1;
    wr_data     = DW'(135);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    wr_valid    = 1'b0;
    chk("tick_write_level", level, 10);

    for (int v = 126; v <= 135; v++) begin
      tick(v);
      idle(1);
    end
    chk("last_sample_level0", level, 0);
    chk("no_underrun_yet", underrun, 0);

    // Underrun with a coincident clear: the flag must stay set
    sb.push_back(DW'(HoldVal));
    sample_tick  = 1'b1;
    clr_underrun = 1'b1;
    @(posedge clk);
    #1;
    sample_tick  = 1'b0;
    clr_underrun = 1'b0;
    chk("underrun_beats_clear", underrun, 1);
    chk("underrun_level", level, 0);
    clr_underrun = 1'b1;
    idle(1);
    clr_underrun = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Back in FILL: a tick with data present still does not pop
    write_n(150, 1);
    tick(HoldVal);
    idle(1);
    chk("refill_tick_no_pop", level, 1);

    // Refill, then drain to 37 and reset mid-stream
    write_n(201, 63);
    idle(3);
    tick(150);
    idle(1);
    for (int v = 201; v <= 225; v++) begin
      tick(v);
      idle(1);
    end
    chk("pre_reset_level38", level, 38);
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    chk("pre_reset_dac_data", dac_data, 226);
    chk("pre_reset_dac_valid", dac_valid, 1);
    chk("pre_reset_level37", level, 37);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_dac_data", dac_data, 0);
    chk("async_reset_dac_valid", dac_valid, 0);
    chk("async_reset_level", level, 0);
    chk("async_reset_ready", wr_ready, 1);
    chk("async_reset_underrun", underrun, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // After reset, silence until a fresh prefill completes
    tick(0);
    idle(1);
    chk("post_reset_level", level, 0);
    write_n(301, 63);
    tick(0);
    idle(1);
    chk("post_reset_fill63", level, 63);
    write_n(364, 1);
    idle(3);
    tick(301);
    chk("post_reset_first_pop", level, 63);

    idle(4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
